vedic_mac: RTL and testbench
============================

# vedic_mac

Sequential multiply-accumulate stage sitting directly downstream of the combinational `vedic_8X8` multiplier. It accepts a stream of 8-bit operand pairs over a valid/ready handshake, forms each 16-bit product with `vedic_8X8`, and accumulates a programmable-length dot product. The result is presented on an output valid/ready handshake. It is the first clocked consumer of the multiplier and the block used for dot-product and filter-tap workloads.

## Interface
- `ACC_W`, 24: accumulator width in bits; minimum 16.
- `CNT_W`, 8: width of the length field; maximum 2^CNT_W−1 beats per run.

- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a new run; sampled only in IDLE.
- `len` in CNT_W: number of operand pairs in the run; sampled with `start`.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block accepts a pair this cycle.
- `a` in 8: multiplicand, unsigned.
- `b` in 8: multiplier, unsigned.
- `out_valid` out 1: `acc` and `overflow` hold the final result.
- `out_ready` in 1: consumer takes the result.
- `acc` out ACC_W: accumulated sum, unsigned, modulo 2^ACC_W.
- `overflow` out 1: sticky; set if any accumulate carried out of bit ACC_W−1 during the run.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 clears `acc`, `overflow` and the pipeline valids.
  - It loads `remaining`=`len`.
  - If `len`=0, the next state is DONE; otherwise RUN.
- RUN:
  - `in_ready` = (`remaining`≠0).
  - A beat is accepted when `in_valid`&`in_ready`; it decrements `remaining`.
  - When the last beat is accepted, the next state is DRAIN.
- DRAIN:
  - `in_ready`=0.
  - Move to DONE on the cycle the final product is added (stage-3 write of the last beat).
- DONE:
  - `out_valid`=1; `acc` and `overflow` are stable.
  - On `out_valid`&`out_ready`, go to IDLE.
  - `acc` and `overflow` keep their values until the next `start`.
- Pipeline:
  - S1 registers `a`,`b` into `a_q`,`b_q` with valid `v1` on acceptance.
  - S2 registers `p_q` = `vedic_8X8`(`a_q`,`b_q`), 16 bits, with valid `v2`.
  - S3 computes `acc` ← `acc` + zero-extended `p_q` when `v2`=1.
  - S3 sets `overflow` on carry out of ACC_W.
- Pipeline stages advance unconditionally; there is no stall inside the pipeline. Backpressure exists only at `in_ready`.
- `start` outside IDLE is ignored, with no effect on state or outputs.
- `in_valid` outside RUN is ignored; no beat is consumed.
- Reset mid-run discards all in-flight beats. There is no partial result.

## Timing
- Reset values:
  - state=IDLE.
  - `in_ready`=0, `out_valid`=0, `busy`=0.
  - `acc`=0, `overflow`=0.
  - `remaining`=0, `v1`=`v2`=0.
- First possible acceptance: the cycle after `start`.
- Throughput: one pair per cycle in RUN.
- Latency: the final beat is accepted at edge N. `v1` rises at N, `v2` at N+1, `acc` updates at N+2. `out_valid` is high from N+3.
- `len`=0: `out_valid` goes high 2 cycles after `start` (IDLE→DONE, then registered output), with `acc`=0.
- `out_valid` is held until the handshake completes. It drops the cycle after `out_ready`=1.
- Earliest next `start` is accepted the cycle after the output handshake.

## Structure
- Shared package `vedic_pkg` holds:
  - the FSM state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - the operand width constant 8 and product width constant 16, also used by `vedic_8X8`.
- The single sub-module is the existing `vedic_8X8`, instantiated once between S1 and S2. No new sub-module is added.
- Pipeline registers and the FSM live in `vedic_mac`.

## Test plan
- len=1, a=255, b=255 with `out_ready`=1 → `acc`=65025, `overflow`=0. `out_valid` rises 3 cycles after acceptance and lasts 1 cycle.
- len=4, back-to-back pairs (5,3),(4,2),(2,2),(6,8) → `acc`=75. `in_ready` falls after the 4th acceptance.
- ACC_W=16, len=2, both pairs (255,255) → `acc`=64514, `overflow`=1.
- len=3 with `in_valid` gaps of 2 cycles and `out_ready` low for 5 cycles in DONE:
  - `acc` is correct and `out_valid` is held.
  - A `start` pulse in DONE is ignored.
- Deassert `rst_n` after 2 of 4 beats → all outputs return to reset values immediately. A fresh `start`, len=1, (6,8) gives `acc`=48.
- `start` with len=0 → `out_valid` after 2 cycles, `acc`=0, and no beat is accepted.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared definitions for the vedic multiplier and the MAC stage built on it.
package vedic_pkg;

    localparam int OPND_W = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/vedic_mac_if.sv
// Operand-in / result-out handshake bundle of vedic_mac.
interface vedic_mac_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);

    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a;
    logic [7:0]       b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc;
    logic             overflow;
    logic             busy;

    modport master (
        output start, len, in_valid, a, b, out_ready,
        input  in_ready, out_valid, acc, overflow, busy
    );

    modport slave (
        input  start, len, in_valid, a, b, out_ready,
        output in_ready, out_valid, acc, overflow, busy
    );

endinterface

// File: rtl/vedic_8X8.sv
// Combinational 8x8 unsigned multiplier, Urdhva-Tiryagbhyam (vertical and crosswise) on nibbles.
module vedic_8X8
    import vedic_pkg::*;
(
    input  logic [OPND_W-1:0] i_a,
    input  logic [OPND_W-1:0] i_b,
    output logic [PROD_W-1:0] o_p
);

    logic [7:0] w_ll;
    logic [7:0] w_lh;
    logic [7:0] w_hl;
    logic [7:0] w_hh;
    logic [8:0] w_cross;

    assign w_ll    = {4'b0, i_a[3:0]} * {4'b0, i_b[3:0]};
    assign w_lh    = {4'b0, i_a[3:0]} * {4'b0, i_b[7:4]};
    assign w_hl    = {4'b0, i_a[7:4]} * {4'b0, i_b[3:0]};
    assign w_hh    = {4'b0, i_a[7:4]} * {4'b0, i_b[7:4]};
    assign w_cross = {1'b0, w_lh} + {1'b0, w_hl};

    // Vertical terms concatenate without overlap; only the crosswise sum needs an adder.
    assign o_p = {w_hh, w_ll} + {3'b0, w_cross, 4'b0};

endmodule

// File: rtl/vedic_mac.sv
// Three-stage multiply-accumulate around vedic_8X8 with a programmable run length.
module vedic_mac
    import vedic_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    vedic_mac_if.slave  bus
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_remaining;
    logic [OPND_W-1:0]  r_a_q;
    logic [OPND_W-1:0]  r_b_q;
    logic               r_v1;
    logic [PROD_W-1:0]  r_p_q;
    logic               r_v2;
    logic [ACC_W-1:0]   r_acc;
    logic               r_overflow;
    logic               r_out_valid;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_launch;
    logic [PROD_W-1:0]  w_prod;
    logic [ACC_W:0]     w_sum;

    vedic_8X8 u_mult (
        .i_a (r_a_q),
        .i_b (r_b_q),
        .o_p (w_prod)
    );

    assign w_launch = (r_state == ST_IDLE) && bus.start;
    assign w_sum    = {1'b0, r_acc} + (ACC_W+1)'(r_p_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                w_in_ready = (r_remaining != '0);
                w_accept   = w_in_ready && bus.in_valid;
                if (w_accept && (r_remaining == CNT_W'(1))) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // No beats enter in DRAIN, so S3 holding the only live beat means it is the last one.
                if (r_v2 && !r_v1) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (r_out_valid && bus.out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_a_q       <= '0;
            r_b_q       <= '0;
            r_v1        <= 1'b0;
            r_p_q       <= '0;
            r_v2        <= 1'b0;
            r_acc       <= '0;
            r_overflow  <= 1'b0;
        end else if (w_launch) begin
            r_remaining <= bus.len;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_acc       <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            if (w_accept) begin
                r_a_q       <= bus.a;
                r_b_q       <= bus.b;
                r_remaining <= r_remaining - CNT_W'(1);
            end
            if (r_v1) begin
                r_p_q <= w_prod;
            end
            if (r_v2) begin
                r_acc      <= w_sum[ACC_W-1:0];
                r_overflow <= r_overflow | w_sum[ACC_W];
            end
        end
    end

    // Result valid lags DONE by one cycle so acc/overflow are settled before it is offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (r_state == ST_DONE) && !(r_out_valid && bus.out_ready);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.acc       = r_acc;
    assign bus.overflow  = r_overflow;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_vedic_mac.sv
// Directed bench for vedic_mac: 24-bit and 16-bit accumulator instances share one stimulus stream.
module tb_vedic_mac;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len = '0;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_ready = 1'b0;

    int unsigned total = 0;
    int unsigned bad = 0;

    typedef struct {
        int unsigned n;
        logic [7:0]  a [4];
        logic [7:0]  b [4];
        int unsigned gap;
        int unsigned hold;
        logic [23:0] acc24;
        logic        ovf24;
        logic [15:0] acc16;
        logic        ovf16;
    } vec_t;

    vec_t vecs [6];
    vec_t rvec;

    vedic_mac_if #(.ACC_W(24), .CNT_W(8)) bus24 ();
    vedic_mac_if #(.ACC_W(16), .CNT_W(8)) bus16 ();

    assign bus24.start     = start;
    assign bus24.len       = len;
    assign bus24.in_valid  = in_valid;
    assign bus24.a         = a;
    assign bus24.b         = b;
    assign bus24.out_ready = out_ready;
    assign bus16.start     = start;
    assign bus16.len       = len;
    assign bus16.in_valid  = in_valid;
    assign bus16.a         = a;
    assign bus16.b         = b;
    assign bus16.out_ready = out_ready;

    vedic_mac #(.ACC_W(24), .CNT_W(8)) u_dut24 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus24.slave)
    );

    vedic_mac #(.ACC_W(16), .CNT_W(8)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int unsigned cyc;
        out_ready = (v.hold == 0);
        start = 1'b1;
        len   = 8'(v.n);
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 32'(bus24.busy), 1);
        for (int i = 0; i < int'(v.n); i++) begin
            a = v.a[i];
            b = v.b[i];
            in_valid = 1'b1;
            cyc = 0;
            while (!bus24.in_ready && cyc < 20) begin
                tick();
                cyc++;
            end
            check({tag, "_in_ready"}, 32'(bus24.in_ready), 1);
            tick();
            in_valid = 1'b0;
            if (i + 1 < int'(v.n)) repeat (v.gap) tick();
        end
        check({tag, "_in_ready_low"}, 32'(bus24.in_ready), 0);
        cyc = 0;
        while (!bus24.out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 3);
        check({tag, "_acc24"}, 32'(bus24.acc), 32'(v.acc24));
        check({tag, "_ovf24"}, 32'(bus24.overflow), 32'(v.ovf24));
        check({tag, "_acc16"}, 32'(bus16.acc), 32'(v.acc16));
        check({tag, "_ovf16"}, 32'(bus16.overflow), 32'(v.ovf16));
        if (v.hold > 0) begin
            start = 1'b1;
            len   = 8'd2;
            tick();
            start = 1'b0;
            check({tag, "_start_ignored_acc"}, 32'(bus24.acc), 32'(v.acc24));
            check({tag, "_start_ignored_ready"}, 32'(bus24.in_ready), 0);
            repeat (v.hold - 1) tick();
            check({tag, "_held_valid"}, 32'(bus24.out_valid), 1);
            check({tag, "_held_acc"}, 32'(bus24.acc), 32'(v.acc24));
            out_ready = 1'b1;
        end
        tick();
        check({tag, "_valid_drop"}, 32'(bus24.out_valid), 0);
        check({tag, "_idle"}, 32'(bus24.busy), 0);
        check({tag, "_acc_kept"}, 32'(bus24.acc), 32'(v.acc24));
    endtask

    initial begin
        vecs[0] = '{n:1, a:'{255, 0, 0, 0}, b:'{255, 0, 0, 0}, gap:0, hold:0,
                    acc24:24'd65025, ovf24:1'b0, acc16:16'd65025, ovf16:1'b0};
        vecs[1] = '{n:4, a:'{5, 4, 2, 6}, b:'{3, 2, 2, 8}, gap:0, hold:0,
                    acc24:24'd75, ovf24:1'b0, acc16:16'd75, ovf16:1'b0};
        vecs[2] = '{n:2, a:'{255, 255, 0, 0}, b:'{255, 255, 0, 0}, gap:0, hold:0,
                    acc24:24'd130050, ovf24:1'b0, acc16:16'd64514, ovf16:1'b1};
        vecs[3] = '{n:3, a:'{10, 7, 100, 0}, b:'{20, 7, 3, 0}, gap:2, hold:5,
                    acc24:24'd549, ovf24:1'b0, acc16:16'd549, ovf16:1'b0};
        vecs[4] = '{n:4, a:'{200, 200, 200, 200}, b:'{200, 200, 200, 200}, gap:0, hold:0,
                    acc24:24'd160000, ovf24:1'b0, acc16:16'd28928, ovf16:1'b1};
        vecs[5] = '{n:3, a:'{0, 1, 128, 0}, b:'{255, 1, 2, 0}, gap:1, hold:0,
                    acc24:24'd257, ovf24:1'b0, acc16:16'd257, ovf16:1'b0};
        rvec    = '{n:1, a:'{6, 0, 0, 0}, b:'{8, 0, 0, 0}, gap:0, hold:0,
                    acc24:24'd48, ovf24:1'b0, acc16:16'd48, ovf16:1'b0};

        repeat (2) tick();
        check("rst_in_ready", 32'(bus24.in_ready), 0);
        check("rst_out_valid", 32'(bus24.out_valid), 0);
        check("rst_busy", 32'(bus24.busy), 0);
        check("rst_acc", 32'(bus24.acc), 0);
        check("rst_ovf", 32'(bus24.overflow), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            tick();
        end

        // len=0: straight to DONE, offered beats are not consumed
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'd9;
        b = 8'd9;
        start = 1'b1;
        len   = 8'd0;
        tick();
        start = 1'b0;
        check("len0_ready", 32'(bus24.in_ready), 0);
        check("len0_valid_early", 32'(bus24.out_valid), 0);
        tick();
        check("len0_valid", 32'(bus24.out_valid), 1);
        check("len0_acc", 32'(bus24.acc), 0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("len0_drop", 32'(bus24.out_valid), 0);
        check("len0_acc_after", 32'(bus24.acc), 0);
        tick();

        // asynchronous reset after two of four beats
        start = 1'b1;
        len   = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        a = 8'd5;
        b = 8'd3;
        tick();
        a = 8'd4;
        b = 8'd2;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("pre_rst_acc", 32'(bus24.acc), 23);
        check("pre_rst_busy", 32'(bus24.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_acc", 32'(bus24.acc), 0);
        check("mid_rst_busy", 32'(bus24.busy), 0);
        check("mid_rst_in_ready", 32'(bus24.in_ready), 0);
        check("mid_rst_out_valid", 32'(bus24.out_valid), 0);
        check("mid_rst_ovf", 32'(bus24.overflow), 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_vec(rvec, "post_rst");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
